// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// an elaboration-time log2 helper.
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One barrel-shifter stage: conditionally shifts/rotates by 2^STAGE and
// registers the result together with the per-operation sideband fields.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int STAGE = 0,
    localparam int S = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [S-1:0]     amt_i,
    input  logic [2:0]       op_i,
    input  logic             fill_i,
    input  logic             carry_i,
    input  logic             illegal_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [S-1:0]     amt_o,
    output logic [2:0]       op_o,
    output logic             fill_o,
    output logic             carry_o,
    output logic             illegal_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int K = 1 << STAGE;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [S-1:0]     amt_q;
    logic [2:0]       op_q;
    logic             fill_q;
    logic             carry_q;
    logic             illegal_q;
    logic             zero_q;
    logic [TAG_W-1:0] tag_q;

    // SRL and SRA share the right-shift path; the fill bit already encodes
    // which of the two it is.
    always_comb begin
        data_d = data_i;
        if (amt_i[STAGE]) begin
            case (op_i)
                OP_SLL:         data_d = {data_i[WIDTH-1-K:0], {K{1'b0}}};
                OP_SRL, OP_SRA: data_d = {{K{fill_i}}, data_i[WIDTH-1:K]};
                OP_ROR:         data_d = {data_i[K-1:0], data_i[WIDTH-1:K]};
                OP_ROL:         data_d = {data_i[WIDTH-1-K:0], data_i[WIDTH-1:WIDTH-K]};
                default:        data_d = data_i;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            amt_q     <= '0;
            op_q      <= '0;
            fill_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            tag_q     <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= valid_i;
            end
            if (en) begin
                data_q    <= data_d;
                amt_q     <= amt_i;
                op_q      <= op_i;
                fill_q    <= fill_i;
                carry_q   <= carry_i;
                illegal_q <= illegal_i;
                zero_q    <= (data_d == '0);
                tag_q     <= tag_i;
            end
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign amt_o     = amt_q;
    assign op_o      = op_q;
    assign fill_o    = fill_q;
    assign carry_o   = carry_q;
    assign illegal_o = illegal_q;
    assign zero_o    = zero_q;
    assign tag_o     = tag_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROR/ROL), one register per
// log2(WIDTH) stage, valid/ready at both ends, lock-step advance.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int S = clog2(WIDTH);
    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_A   = AMT_W'(1);
    localparam logic [S-1:0]     ONE_S   = S'(1);

    logic adv;

    // Index 0 is the decoded request; index k+1 is the output of stage k.
    logic             valid_c   [0:S];
    logic [WIDTH-1:0] data_c    [0:S];
    logic [S-1:0]     amt_c     [0:S];
    logic [2:0]       op_c      [0:S];
    logic             fill_c    [0:S];
    logic             carry_c   [0:S];
    logic             illegal_c [0:S];
    logic [TAG_W-1:0] tag_c     [0:S];
    logic             zero_c    [1:S];

    logic [WIDTH-1:0] dec_data;
    logic [S-1:0]     dec_amt;
    logic             dec_fill;
    logic             dec_carry;
    logic             dec_illegal;
    logic             amt_big;
    logic [S-1:0]     amt_lo;
    logic [AMT_W-1:0] amt_m1;
    logic [AMT_W-1:0] width_m_amt;
    logic [S-1:0]     rot_m1;
    logic [S-1:0]     rot_neg;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign amt_lo      = in_amt[S-1:0];
    assign amt_big     = (in_amt >= WIDTH_A);
    assign amt_m1      = in_amt - ONE_A;
    assign width_m_amt = WIDTH_A - in_amt;
    assign rot_m1      = amt_lo - ONE_S;
    assign rot_neg     = (~amt_lo) + ONE_S;

    // Out-of-range shifts are resolved here by substituting the saturated
    // value with a zero amount, so the stages only ever see amounts < WIDTH.
    // Rotate carries are pre-computed from the operand bit that ends up at
    // the relevant end of the result.
    always_comb begin
        dec_data    = in_data;
        dec_amt     = amt_lo;
        dec_fill    = 1'b0;
        dec_carry   = 1'b0;
        dec_illegal = 1'b0;
        case (in_op)
            OP_SLL: begin
                if (in_amt != '0 && in_amt <= WIDTH_A) begin
                    dec_carry = in_data[width_m_amt[S-1:0]];
                end
                if (amt_big) begin
                    dec_data = '0;
                    dec_amt  = '0;
                end
            end
            OP_SRL, OP_SRA: begin
                dec_fill = (in_op == OP_SRA) && in_data[WIDTH-1];
                if (in_amt != '0) begin
                    dec_carry = (in_amt <= WIDTH_A) ? in_data[amt_m1[S-1:0]] : dec_fill;
                end
                if (amt_big) begin
                    dec_data = {WIDTH{dec_fill}};
                    dec_amt  = '0;
                end
            end
            OP_ROR: begin
                dec_carry = (amt_lo != '0) && in_data[rot_m1];
            end
            OP_ROL: begin
                dec_carry = (amt_lo != '0) && in_data[rot_neg];
            end
            default: begin
                dec_data    = '0;
                dec_amt     = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign valid_c[0]   = in_valid;
    assign data_c[0]    = dec_data;
    assign amt_c[0]     = dec_amt;
    assign op_c[0]      = in_op;
    assign fill_c[0]    = dec_fill;
    assign carry_c[0]   = dec_carry;
    assign illegal_c[0] = dec_illegal;
    assign tag_c[0]     = in_tag;

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STAGE (gi)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .flush_i   (flush),
            .valid_i   (valid_c[gi]),
            .data_i    (data_c[gi]),
            .amt_i     (amt_c[gi]),
            .op_i      (op_c[gi]),
            .fill_i    (fill_c[gi]),
            .carry_i   (carry_c[gi]),
            .illegal_i (illegal_c[gi]),
            .tag_i     (tag_c[gi]),
            .valid_o   (valid_c[gi+1]),
            .data_o    (data_c[gi+1]),
            .amt_o     (amt_c[gi+1]),
            .op_o      (op_c[gi+1]),
            .fill_o    (fill_c[gi+1]),
            .carry_o   (carry_c[gi+1]),
            .illegal_o (illegal_c[gi+1]),
            .zero_o    (zero_c[gi+1]),
            .tag_o     (tag_c[gi+1])
        );
    end

    assign out_valid   = valid_c[S];
    assign out_data    = data_c[S];
    assign out_carry   = carry_c[S];
    assign out_zero    = zero_c[S];
    assign out_illegal = illegal_c[S];
    assign out_tag     = tag_c[S];

endmodule

// File: tb/tb_shifter_pipe.sv
// Self-checking bench for shifter_pipe (WIDTH=16): directed vectors, stalls,
// illegal ops, flush, asynchronous reset and a randomized scoreboard run.
module tb_shifter_pipe;

    localparam int WIDTH = 16;
    localparam int AMT_W = 8;
    localparam int TAG_W = 4;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        zero;
        logic        illegal;
        logic [3:0]  tag;
    } res_t;

    shifter_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_amt      (in_amt),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: place the operand inside a wide word, shift it with native
    // operators and read the result window plus the bit just beyond it.
    function automatic res_t model(input logic [2:0] op, input logic [15:0] d,
                                   input logic [7:0] a, input logic [3:0] tag);
        res_t r;
        logic [63:0] w;
        logic signed [63:0] sw;
        logic [31:0] dd;
        int e;
        r.tag = tag; r.data = '0; r.carry = 1'b0; r.illegal = 1'b0;
        dd = {d, d};
        e = int'(a) % 16;
        case (op)
            3'd0: begin w = {48'b0, d} << a; r.data = w[15:0]; r.carry = w[16]; end
            3'd1: begin w = {32'b0, d, 16'b0} >> a; r.data = w[31:16]; r.carry = w[15]; end
            3'd2: begin
                sw = signed'({{32{d[15]}}, d, 16'b0});
                sw = sw >>> a;
                r.data = sw[31:16]; r.carry = sw[15];
            end
            3'd3: begin w = {32'b0, dd} >> e; r.data = w[15:0]; r.carry = (e != 0) && r.data[15]; end
            3'd4: begin w = {32'b0, dd} << e; r.data = w[31:16]; r.carry = (e != 0) && r.data[0]; end
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.data == 16'h0000);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_carry !== 1'b0 || out_zero !== 1'b0 ||
            out_illegal !== 1'b0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: got v=%b d=%h c=%b z=%b il=%b tag=%h rdy=%b, want all 0 and rdy=1",
                     out_valid, out_data, out_carry, out_zero, out_illegal, out_tag, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [9] = '{3'd0, 3'd2, 3'd2, 3'd1, 3'd3, 3'd4, 3'd4, 3'd0, 3'd2};
        logic [15:0] t_d  [9] = '{16'h00F1, 16'h8001, 16'h8001, 16'h8001, 16'h1234,
                                  16'h8001, 16'hABCD, 16'h8001, 16'h7FFF};
        logic [7:0]  t_a  [9] = '{8'd4, 8'd1, 8'd40, 8'd16, 8'd4, 8'd20, 8'd16, 8'd16, 8'd200};
        logic [15:0] t_x  [9] = '{16'h0F10, 16'hC000, 16'hFFFF, 16'h0000, 16'h4123,
                                  16'h0018, 16'hABCD, 16'h0000, 16'h0000};
        logic        t_c  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  tag;
        for (int i = 0; i < 9; i++) begin
            tag = 4'(i + 3);
            in_valid = 1'b1; in_op = t_op[i]; in_data = t_d[i]; in_amt = t_a[i]; in_tag = tag;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL dir%0d_ready: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 1; c < LAT; c++) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL dir%0d_early: out_valid=%b after %0d cycles, want 0", i, out_valid, c);
                end
                @(posedge clk); #1;
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== t_x[i] || out_carry !== t_c[i] ||
                out_zero !== (t_x[i] == 16'h0) || out_illegal !== 1'b0 || out_tag !== tag) begin
                n_bad++;
                $display("FAIL dir%0d_result: got v=%b d=%h c=%b z=%b il=%b tag=%h, want v=1 d=%h c=%b z=%b il=0 tag=%h",
                         i, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag,
                         t_x[i], t_c[i], (t_x[i] == 16'h0), tag);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 3'(5 + i); in_data = 16'hFFFF; in_amt = 8'(i + 2); in_tag = 4'(9 + i);
            #1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (LAT - 2) @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal%0d_early: out_valid=%b one cycle before latency, want 0", i, out_valid);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 16'h0 || out_carry !== 1'b0 || out_zero !== 1'b1 ||
                out_illegal !== 1'b1 || out_tag !== 4'(9 + i)) begin
                n_bad++;
                $display("FAIL illegal%0d_result: got v=%b d=%h c=%b z=%b il=%b tag=%h, want v=1 d=0000 c=0 z=1 il=1 tag=%h",
                         i, out_valid, out_data, out_carry, out_zero, out_illegal, out_tag, 4'(9 + i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t exp_r;
        res_t held;
        logic [15:0] d [6];
        logic [7:0]  a [6];
        logic [2:0]  o [6];
        int sent = 0, got = 0, low_cnt = 0;
        logic stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d[i] = 16'($urandom); a[i] = 8'($urandom_range(0, 17)); o[i] = 3'($urandom_range(0, 4));
        end
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_data = d[sent]; in_amt = a[sent]; in_op = o[sent]; in_tag = 4'(sent);
            end
            #1;
            n_cmp++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_bad++;
                $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, in_ready, (!out_valid || out_ready));
            end
            if (!in_ready) low_cnt++;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held.data || out_carry !== held.carry ||
                    out_tag !== held.tag || out_zero !== held.zero) begin
                    n_bad++;
                    $display("FAIL b2b_hold cyc%0d: got v=%b d=%h tag=%h, want v=1 d=%h tag=%h",
                             cyc, out_valid, out_data, out_tag, held.data, held.tag);
                end
            end
            stalled = out_valid && !out_ready;
            held.data = out_data; held.carry = out_carry; held.zero = out_zero;
            held.illegal = out_illegal; held.tag = out_tag;
            if (out_valid && out_ready) begin
                n_cmp++;
                exp_r = q.pop_front();
                if (out_data !== exp_r.data || out_carry !== exp_r.carry || out_zero !== exp_r.zero ||
                    out_illegal !== exp_r.illegal || out_tag !== exp_r.tag) begin
                    n_bad++;
                    $display("FAIL b2b_result%0d: got d=%h c=%b z=%b tag=%h, want d=%h c=%b z=%b tag=%h",
                             got, out_data, out_carry, out_zero, out_tag,
                             exp_r.data, exp_r.carry, exp_r.zero, exp_r.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_data, in_amt, in_tag));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 6 || low_cnt != 3) begin
            n_bad++;
            $display("FAIL b2b_counts: got results=%0d in_ready_low=%0d, want 6 and 3", got, low_cnt);
        end
    endtask

    task automatic test_flush();
        res_t exp_r;
        int bad_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 3'($urandom_range(0, 4)); in_data = 16'($urandom) | 16'h0101;
            in_amt = 8'(i); in_tag = 4'(i); flush = (i == 3);
            #1;
            if (i == 3) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL flush_in_ready: got %b want 1", in_ready);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0) bad_cycles++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL flush_no_output: out_valid seen on %0d cycles, want 0", bad_cycles);
        end
        in_valid = 1'b1; in_op = 3'd3; in_data = 16'hBEEF; in_amt = 8'd7; in_tag = 4'hA;
        exp_r = model(in_op, in_data, in_amt, in_tag);
        #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_r.data || out_carry !== exp_r.carry || out_tag !== exp_r.tag) begin
            n_bad++;
            $display("FAIL flush_after: got v=%b d=%h c=%b tag=%h, want v=1 d=%h c=%b tag=%h",
                     out_valid, out_data, out_carry, out_tag, exp_r.data, exp_r.carry, exp_r.tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        res_t exp_r;
        int bad_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 3'd0; in_data = 16'h1235 + 16'(i); in_amt = 8'd0; in_tag = 4'(i + 1);
            #1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_carry !== 1'b0 || out_zero !== 1'b0 ||
            out_illegal !== 1'b0 || out_tag !== 4'h0) begin
            n_bad++;
            $display("FAIL async_reset_outputs: got v=%b d=%h c=%b z=%b il=%b tag=%h, want all 0",
                     out_valid, out_data, out_carry, out_zero, out_illegal, out_tag);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset_ready: got %b want 1", in_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL async_reset_discard: out_valid seen on %0d cycles, want 0", bad_cycles);
        end
        in_valid = 1'b1; in_op = 3'd2; in_data = 16'h9C40; in_amt = 8'd5; in_tag = 4'h6;
        exp_r = model(in_op, in_data, in_amt, in_tag);
        #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_r.data || out_carry !== exp_r.carry || out_tag !== exp_r.tag) begin
            n_bad++;
            $display("FAIL async_reset_after: got v=%b d=%h c=%b tag=%h, want v=1 d=%h c=%b tag=%h",
                     out_valid, out_data, out_carry, out_tag, exp_r.data, exp_r.carry, exp_r.tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        res_t q[$];
        res_t exp_r;
        int sent = 0, got = 0, errs = 0;
        for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid = (sent < 300) && ($urandom_range(0, 9) < 7);
            in_op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            in_amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            in_data = 16'($urandom);
            in_tag = 4'($urandom);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                exp_r = q.pop_front();
                if (out_data !== exp_r.data || out_carry !== exp_r.carry || out_zero !== exp_r.zero ||
                    out_illegal !== exp_r.illegal || out_tag !== exp_r.tag) begin
                    n_bad++; errs++;
                    if (errs < 10)
                        $display("FAIL rand_result%0d: got d=%h c=%b z=%b il=%b tag=%h, want d=%h c=%b z=%b il=%b tag=%h",
                                 got, out_data, out_carry, out_zero, out_illegal, out_tag,
                                 exp_r.data, exp_r.carry, exp_r.zero, exp_r.illegal, exp_r.tag);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_op, in_data, in_amt, in_tag));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != 300) begin
            n_bad++;
            $display("FAIL rand_timeout: got %0d results, want 300", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational shifter.
- Performs SLL/SRL/SRA/ROR/ROL on a WIDTH-bit operand as a log2(WIDTH)-stage barrel shifter, with one register per stage.
- Uses a valid/ready handshake at both ends, plus a carry-out flag, a zero flag and tag pass-through.
- Sits between the register-read stage and ALU writeback in the datapath.

Parameters:
- WIDTH, 16: operand width; power of two, 8..64.
- AMT_W, 8: shift-amount port width; must be >= log2(WIDTH)+1.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; kills all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  pipeline can accept a request this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  unsigned shift amount.
- in_op  in  3  operation code: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101..111 illegal.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.
- out_illegal  out  1  op was 101..111.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits and out_valid = 0; out_data, out_carry, out_zero, out_illegal, out_tag = 0. in_ready is 1 out of reset.
- Structure: S = log2(WIDTH) register stages. Latency is exactly S cycles from handshake to out_valid when there is no stall (WIDTH=16 gives 4).
- Stage 0 captures the request. It computes:
  - the effective amount;
  - fill bit: 0, or in_data[WIDTH-1] for SRA;
  - the carry;
  - the illegal flag.
- Stage k (k = 0..S-1) shifts by 2^k when effective-amount bit k is set.
- Advance rule: adv = !out_valid || out_ready. All stages advance together on adv.
  - in_ready = adv.
  - A handshake is in_valid && in_ready.
  - Bubbles are not compressed.
  - Outputs hold stable while out_valid && !out_ready.
- Amount rules, with A = in_amt:
  - SLL/SRL, A >= WIDTH: result 0.
  - SRA, A >= WIDTH: result is the sign bit replicated across all WIDTH bits.
  - ROR/ROL: effective amount = A mod WIDTH.
  - A == 0, or a rotate with A mod WIDTH == 0: result = data, carry = 0.
- Carry rules, for a nonzero effective shift:
  - SLL: carry = data[WIDTH-A] when A <= WIDTH, else 0.
  - SRL/SRA: carry = data[A-1] when A <= WIDTH. Otherwise 0 for SRL and the sign bit for SRA.
  - ROR: carry = result[WIDTH-1].
  - ROL: carry = result[0].
- Illegal op: result 0, carry 0, zero 1, illegal 1. The operation still occupies the pipe and completes normally.
- out_zero is computed on the final stage's result.
- flush: on the next edge all valid bits are cleared; data registers are don't-care. flush overrides a same-cycle input handshake, which is dropped. in_ready is unaffected.
- Reset mid-operation: all in-flight operations are discarded with no output. This is the only way besides flush to lose an accepted request.
- Ordering: results emerge in acceptance order, with tags unmodified.

Decomposition:
- Package shifter_pkg holds:
  - op encodings as localparams: OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL;
  - a function clog2.
- Sub-module shifter_stage, parameters WIDTH, TAG_W, STAGE:
  - one conditional 2^STAGE shift/rotate plus its pipeline register;
  - ports en, clk, rst_n.
- shifter_pipe instantiates S copies of shifter_stage via generate, plus the stage-0 decode logic.

Test Plan (WIDTH=16, AMT_W=8, out_ready=1 unless stated):
- SLL 0x00F1 by 4, tag 3 -> 4 cycles later: out_data 0x0F10, carry 0, zero 0, tag 3.
- SRA 0x8001 by 1 -> 0xC000, carry 1. SRA 0x8001 by 40 -> 0xFFFF, carry 1. SRL 0x8001 by 16 -> 0x0000, carry 1, zero 1.
- ROR 0x1234 by 4 -> 0x4123, carry 0. ROL 0x8001 by 20 -> 0x0018, carry 0. ROL 0xABCD by 16 -> 0xABCD, carry 0.
- Back-to-back: 6 requests on consecutive cycles, out_ready low for 3 cycles mid-stream -> in_ready low exactly while out_valid && !out_ready, all 6 results in order, outputs stable while stalled.
- Illegal op 3'b110 on 0xFFFF -> out_data 0, zero 1, illegal 1, carry 0, latency unchanged.
- Flush and reset: 3 requests in flight, then flush for 1 cycle -> no out_valid afterward, a new request completes normally. Repeat with rst_n low mid-stream -> all outputs 0 immediately (asynchronous), in_ready 1 after release.
